// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multiplier/result-memory block between two
// requesters; caps issue at DEPTH products and routes read-back beats to their owner.
module mult_arbiter #(
  parameter int N          = 32,
  parameter int DEPTH      = 64,
  parameter int AUTO_DRAIN = 1
) (
  input  logic          CLK,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [15:0]   a0,
  input  logic [15:0]   b0,
  output logic          gnt0,
  input  logic          req1,
  input  logic [15:0]   a1,
  input  logic [15:0]   b1,
  output logic          gnt1,
  input  logic          drain_req,
  output logic          rsp0_valid,
  output logic          rsp1_valid,
  output logic [N-1:0]  rsp_data,
  input  logic          mult_rdy,
  output logic          mult_en,
  output logic [15:0]   mult_in0,
  output logic [15:0]   mult_in1,
  output logic          block_read_en,
  input  logic          mem_valid,
  input  logic [N-1:0]  mem_data,
  output logic          drain_busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    issue_cnt_r, issue_cnt_s;
  logic [AW-1:0]    beat_cnt_r, beat_cnt_s;
  logic [DEPTH-1:0] owner_r, owner_s;
  logic             rr_ptr_r, rr_ptr_s;

  logic             can_issue_s;
  logic             winner_s;
  logic             grant_s;
  logic             beat_s;
  logic             beat_owner_s;

  // Arbitration and read-back routing; grants are masked while reset is held
  always_comb begin
    can_issue_s  = rst_n && (state_r == ISSUE) && mult_rdy && (issue_cnt_r < CW'(DEPTH));
    winner_s     = 1'b0;
    if (req0 && req1) begin
      winner_s = rr_ptr_r;
    end else begin
      winner_s = req1;
    end
    grant_s      = can_issue_s && (req0 || req1);
    beat_s       = ((state_r == FULL) || (state_r == DRAIN)) && mem_valid;
    beat_owner_s = owner_r[beat_cnt_r];
  end

  // Next-state, counter and ownership-bitmap update
  always_comb begin
    state_s     = state_r;
    issue_cnt_s = issue_cnt_r;
    beat_cnt_s  = beat_cnt_r;
    owner_s     = owner_r;
    rr_ptr_s    = rr_ptr_r;
    case (state_r)
      ISSUE: begin
        if (grant_s) begin
          owner_s[issue_cnt_r[AW-1:0]] = winner_s;
          issue_cnt_s = issue_cnt_r + CW'(1);
          rr_ptr_s    = ~winner_s;
          if (issue_cnt_r == CW'(DEPTH - 1)) begin
            state_s = FULL;
          end else begin
            state_s = ISSUE;
          end
        end else begin
          state_s = ISSUE;
        end
      end
      FULL, DRAIN: begin
        if (beat_s) begin
          if (beat_cnt_r == AW'(DEPTH - 1)) begin
            issue_cnt_s = {CW{1'b0}};
            beat_cnt_s  = {AW{1'b0}};
            owner_s     = {DEPTH{1'b0}};
            state_s     = ISSUE;
          end else begin
            beat_cnt_s  = beat_cnt_r + AW'(1);
            state_s     = DRAIN;
          end
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ISSUE;
      end
    endcase
  end

  // State, counters, bitmap and round-robin pointer
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ISSUE;
      issue_cnt_r <= {CW{1'b0}};
      beat_cnt_r  <= {AW{1'b0}};
      owner_r     <= {DEPTH{1'b0}};
      rr_ptr_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      issue_cnt_r <= issue_cnt_s;
      beat_cnt_r  <= beat_cnt_s;
      owner_r     <= owner_s;
      rr_ptr_r    <= rr_ptr_s;
    end
  end

  // Output drive; handshake and routing are same-cycle by design
  always_comb begin
    gnt0          = grant_s && !winner_s;
    gnt1          = grant_s && winner_s;
    mult_en       = grant_s;
    mult_in0      = 16'd0;
    mult_in1      = 16'd0;
    if (grant_s) begin
      mult_in0 = winner_s ? a1 : a0;
      mult_in1 = winner_s ? b1 : b0;
    end else begin
      mult_in0 = 16'd0;
      mult_in1 = 16'd0;
    end
    block_read_en = (state_r == FULL) && ((AUTO_DRAIN != 0) || drain_req);
    drain_busy    = (state_r != ISSUE);
    rsp0_valid    = beat_s && !beat_owner_s;
    rsp1_valid    = beat_s && beat_owner_s;
    rsp_data      = beat_s ? mem_data : {N{1'b0}};
  end

  mult_arbiter_chk u_chk (
    .clk        (CLK),
    .rst_n      (rst_n),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .mult_en    (mult_en),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .drain_busy (drain_busy)
  );

endmodule

// Handshake invariants of the arbiter outputs.
module mult_arbiter_chk (
  input logic clk,
  input logic rst_n,
  input logic gnt0,
  input logic gnt1,
  input logic mult_en,
  input logic rsp0_valid,
  input logic rsp1_valid,
  input logic drain_busy
);

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(gnt0 && gnt1));
  a_rsp_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(rsp0_valid && rsp1_valid));
  a_en_is_gnt:  assert property (@(posedge clk) disable iff (!rst_n) mult_en == (gnt0 || gnt1));
  a_busy_nognt: assert property (@(posedge clk) disable iff (!rst_n) !(drain_busy && (gnt0 || gnt1)));

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: AUTO_DRAIN=1 instance plus an AUTO_DRAIN=0 instance.
`timescale 1ns/1ps
module tb_mult_arbiter;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        req0, req1, drain_req, mult_rdy, mem_valid;
  logic [15:0] a0, b0, a1, b1;
  logic [31:0] mem_data;
  logic        gnt0, gnt1, rsp0_valid, rsp1_valid, mult_en, block_read_en, drain_busy;
  logic [31:0] rsp_data;
  logic [15:0] mult_in0, mult_in1;

  logic        u1_req0, u1_drain_req, u1_mem_valid;
  logic        u1_gnt0, u1_gnt1, u1_rsp0_valid, u1_rsp1_valid, u1_mult_en;
  logic        u1_block_read_en, u1_drain_busy;
  logic [31:0] u1_rsp_data;
  logic [15:0] u1_mult_in0, u1_mult_in1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  mult_arbiter #(.N(32), .DEPTH(64), .AUTO_DRAIN(1)) u0 (
    .CLK(CLK), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1),
    .drain_req(drain_req),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .mult_rdy(mult_rdy), .mult_en(mult_en), .mult_in0(mult_in0), .mult_in1(mult_in1),
    .block_read_en(block_read_en), .mem_valid(mem_valid), .mem_data(mem_data),
    .drain_busy(drain_busy)
  );

  mult_arbiter #(.N(32), .DEPTH(64), .AUTO_DRAIN(0)) u1 (
    .CLK(CLK), .rst_n(rst_n),
    .req0(u1_req0), .a0(a0), .b0(b0), .gnt0(u1_gnt0),
    .req1(1'b0), .a1(a1), .b1(b1), .gnt1(u1_gnt1),
    .drain_req(u1_drain_req),
    .rsp0_valid(u1_rsp0_valid), .rsp1_valid(u1_rsp1_valid), .rsp_data(u1_rsp_data),
    .mult_rdy(mult_rdy), .mult_en(u1_mult_en), .mult_in0(u1_mult_in0), .mult_in1(u1_mult_in1),
    .block_read_en(u1_block_read_en), .mem_valid(u1_mem_valid), .mem_data(mem_data),
    .drain_busy(u1_drain_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".gnt0"}, gnt0, 1'b0);
    chk({tag, ".gnt1"}, gnt1, 1'b0);
    chk({tag, ".mult_en"}, mult_en, 1'b0);
    chk({tag, ".block_read_en"}, block_read_en, 1'b0);
    chk({tag, ".rsp0_valid"}, rsp0_valid, 1'b0);
    chk({tag, ".rsp1_valid"}, rsp1_valid, 1'b0);
    chk({tag, ".drain_busy"}, drain_busy, 1'b0);
  endtask

  task automatic issue_one(input bit p, input logic [15:0] a, input logic [15:0] b);
    req0 = !p;
    req1 = p;
    a0 = a; b0 = b; a1 = a; b1 = b;
    @(negedge CLK);
    chk("issue.gnt0", gnt0, !p);
    chk("issue.gnt1", gnt1, p);
    chk("issue.mult_en", mult_en, 1'b1);
    chk("issue.mult_in0", mult_in0, a);
    chk("issue.mult_in1", mult_in1, b);
    step();
  endtask

  task automatic beat(input logic [31:0] d, input bit p);
    mem_valid = 1'b1;
    mem_data  = d;
    @(negedge CLK);
    chk("beat.rsp0_valid", rsp0_valid, !p);
    chk("beat.rsp1_valid", rsp1_valid, p);
    chk("beat.rsp_data", rsp_data, d);
    chk("beat.drain_busy", drain_busy, 1'b1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b0; drain_req = 1'b0; mult_rdy = 1'b1;
    mem_valid = 1'b0; mem_data = 32'd0; a0 = 16'd0; b0 = 16'd0; a1 = 16'd0; b1 = 16'd0;
    u1_req0 = 1'b0; u1_drain_req = 1'b0; u1_mem_valid = 1'b0;

    // Reset: outputs quiet even with a live request
    #2;
    check_idle("rst");
    repeat (3) @(posedge CLK);
    #1;
    req0 = 1'b0;
    rst_n = 1'b1;

    // Port 0 only, 64 back-to-back, then read-out of 3*i
    for (int i = 0; i < 64; i++) issue_one(1'b0, i[15:0], 16'd3);
    @(negedge CLK);
    chk("full.gnt0", gnt0, 1'b0);
    chk("full.mult_en", mult_en, 1'b0);
    chk("full.block_read_en", block_read_en, 1'b1);
    chk("full.drain_busy", drain_busy, 1'b1);
    step();
    req0 = 1'b0;
    for (int i = 0; i < 64; i++) beat(32'(3 * i), 1'b0);
    mem_valid = 1'b0;
    @(negedge CLK);
    chk("t1.done.drain_busy", drain_busy, 1'b0);
    chk("t1.done.block_read_en", block_read_en, 1'b0);
    step();

    // AUTO_DRAIN=0 instance: waits for drain_req
    u1_req0 = 1'b1;
    for (int i = 0; i < 64; i++) begin
      a0 = i[15:0]; b0 = 16'd7;
      @(negedge CLK);
      chk("u1.gnt0", u1_gnt0, 1'b1);
      chk("u1.gnt1", u1_gnt1, 1'b0);
      chk("u1.mult_en", u1_mult_en, 1'b1);
      chk("u1.mult_in0", u1_mult_in0, i[15:0]);
      chk("u1.mult_in1", u1_mult_in1, 16'd7);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("u1.hold.gnt0", u1_gnt0, 1'b0);
      chk("u1.hold.block_read_en", u1_block_read_en, 1'b0);
      chk("u1.hold.drain_busy", u1_drain_busy, 1'b1);
      step();
    end
    u1_req0 = 1'b0;
    u1_drain_req = 1'b1;
    @(negedge CLK);
    chk("u1.drain.block_read_en", u1_block_read_en, 1'b1);
    step();
    for (int i = 0; i < 64; i++) begin
      u1_mem_valid = 1'b1;
      mem_data = 32'(7 * i);
      @(negedge CLK);
      chk("u1.beat.rsp0_valid", u1_rsp0_valid, 1'b1);
      chk("u1.beat.rsp1_valid", u1_rsp1_valid, 1'b0);
      chk("u1.beat.rsp_data", u1_rsp_data, 32'(7 * i));
      step();
      u1_drain_req = 1'b0;
    end
    u1_mem_valid = 1'b0;
    @(negedge CLK);
    chk("u1.done.drain_busy", u1_drain_busy, 1'b0);
    step();

    // Fresh start, both requesting: strict alternation with a 5-cycle mult_rdy stall
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    a0 = 16'h00FF; b0 = 16'h0101; a1 = 16'h1234; b1 = 16'h0002;
    for (int k = 0; k < 64; k++) begin
      if (k == 10) begin
        mult_rdy = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge CLK);
          chk("stall.gnt0", gnt0, 1'b0);
          chk("stall.gnt1", gnt1, 1'b0);
          chk("stall.mult_en", mult_en, 1'b0);
          chk("stall.mult_in0", mult_in0, 16'd0);
          step();
        end
        mult_rdy = 1'b1;
      end
      @(negedge CLK);
      chk("rr.gnt0", gnt0, !k[0]);
      chk("rr.gnt1", gnt1, k[0]);
      chk("rr.mult_in0", mult_in0, k[0] ? 16'h1234 : 16'h00FF);
      chk("rr.mult_in1", mult_in1, k[0] ? 16'h0002 : 16'h0101);
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int k = 0; k < 64; k++) beat(k[0] ? 32'h0000_2468 : 32'h0000_FFFF, k[0]);
    mem_valid = 1'b0;

    // Reset in the middle of a read-out
    for (int i = 0; i < 64; i++) issue_one(1'b0, 16'(i + 1), 16'd2);
    req0 = 1'b0;
    for (int i = 0; i < 30; i++) beat(32'(2 * (i + 1)), 1'b0);
    mem_valid = 1'b1;
    mem_data = 32'd62;
    rst_n = 1'b0;
    #1;
    check_idle("rst_mid");
    chk("rst_mid.rsp_data", rsp_data, 32'd0);
    step();
    mem_valid = 1'b0;
    rst_n = 1'b1;

    // Spurious mem_valid in ISSUE is ignored and does not advance the beat counter
    mem_valid = 1'b1;
    mem_data = 32'hDEAD_BEEF;
    @(negedge CLK);
    chk("spur.rsp0_valid", rsp0_valid, 1'b0);
    chk("spur.rsp1_valid", rsp1_valid, 1'b0);
    chk("spur.drain_busy", drain_busy, 1'b0);
    step();
    mem_valid = 1'b0;
    issue_one(1'b1, 16'h0011, 16'h0022);
    for (int i = 1; i < 64; i++) begin
      issue_one(1'b0, 16'(i), 16'd5);
      chk("count.drain_busy", drain_busy, i == 63);
    end
    req0 = 1'b0;
    chk("count.block_read_en", block_read_en, 1'b1);
    beat(32'h0000_0242, 1'b1);
    for (int i = 1; i < 64; i++) beat(32'(5 * i), 1'b0);
    mem_valid = 1'b0;
    @(negedge CLK);
    chk("end.drain_busy", drain_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
